// File: rtl/print_hex_gen.sv
// print_hex_gen: streams a captured value as raw bytes or ASCII hex, with optional "0x" prefix and CR/LF suffix.
module print_hex_gen #(
  parameter int DATA_W    = 32,
  parameter int PREFIX_EN = 0,
  parameter int LOWER     = 0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] din,
  input  logic [1:0]        mode,
  input  logic              nl,
  input  logic              req_tx,
  output logic              ack_tx,
  output logic [7:0]        d_tx,
  output logic              vld_tx,
  input  logic              rdy_tx,
  output logic              busy
);
  localparam int NDIG  = DATA_W / 4;
  localparam int NBYTE = DATA_W / 8;
  localparam int CW    = $clog2(NDIG + 5);

  typedef enum logic [1:0] {IDLE, EMIT, ACK} state_t;

  state_t            state_q;
  logic [DATA_W-1:0] din_q;
  logic [1:0]        mode_q;
  logic              nl_q;
  logic [CW-1:0]     cnt_q;
  logic [7:0]        d_tx_q;
  logic              vld_q, ack_q;

  logic [DATA_W-1:0] v;
  logic [1:0]        m;
  logic              n, hex;
  logic [CW-1:0]     idx, pre, npay, len, p, k, kb;
  logic [3:0]        nib;
  logic [7:0]        raw, asc, byte_d;

  function automatic logic [CW-1:0] lead_zeros(input logic [DATA_W-1:0] x);
    lead_zeros = CW'(NDIG - 1);
    for (int i = 0; i < NDIG; i++)
      if (x[4*i +: 4] != '0) lead_zeros = CW'(NDIG - 1 - i);
  endfunction

  // In IDLE the first byte is derived straight from the inputs so it can be registered on the acceptance edge.
  always_comb begin
    v      = (state_q == IDLE) ? din : din_q;
    m      = (state_q == IDLE) ? mode : mode_q;
    n      = (state_q == IDLE) ? nl : nl_q;
    idx    = (state_q == IDLE) ? '0 : cnt_q + CW'(1);
    hex    = (m == 2'b01) || (m == 2'b10);
    pre    = (PREFIX_EN != 0 && hex) ? CW'(2) : '0;
    npay   = (m == 2'b00) ? CW'(1) : (m == 2'b11) ? CW'(NBYTE) :
             (m == 2'b01) ? CW'(NDIG) : CW'(NDIG) - lead_zeros(v);
    len    = pre + npay + (n ? CW'(2) : '0);
    p      = idx - pre;
    k      = npay - CW'(1) - p;
    kb     = CW'(NBYTE) - CW'(1) - p;
    nib    = 4'(v >> {k, 2'b00});
    raw    = (m == 2'b00) ? v[7:0] : 8'(v >> {kb, 3'b000});
    asc    = (nib < 4'd10) ? 8'h30 + {4'h0, nib} : ((LOWER != 0) ? 8'h57 : 8'h37) + {4'h0, nib};
    byte_d = (idx < pre) ? ((idx == '0) ? 8'h30 : 8'h78) :
             (p < npay) ? (hex ? asc : raw) :
             (p == npay) ? 8'h0D : 8'h0A;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      din_q   <= '0;
      mode_q  <= '0;
      nl_q    <= 1'b0;
      cnt_q   <= '0;
      d_tx_q  <= '0;
      vld_q   <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_tx) begin
          din_q   <= din;
          mode_q  <= mode;
          nl_q    <= nl;
          cnt_q   <= '0;
          d_tx_q  <= byte_d;
          vld_q   <= 1'b1;
          state_q <= EMIT;
        end
        EMIT: if (rdy_tx) begin
          if (idx == len) begin
            vld_q   <= 1'b0;
            d_tx_q  <= '0;
            ack_q   <= 1'b1;
            state_q <= ACK;
          end else begin
            cnt_q  <= idx;
            d_tx_q <= byte_d;
          end
        end
        ACK: if (!req_tx) begin
          ack_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_tx   = d_tx_q;
  assign vld_tx = vld_q;
  assign ack_tx = ack_q;
  assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_print_hex_gen.sv
// tb_print_hex_gen: drives three print_hex_gen variants (plain, lowercase, prefixed) against a byte-sequence model.
module tb_print_hex_gen;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] din = '0;
  logic [1:0]  mode = '0;
  logic        nl = 1'b0;
  logic [2:0]  req = '0, rdy = '0, ack, vld, busy;
  logic [7:0]  dtx [3];
  logic [7:0]  exp_q [$];
  int          vec = 0, miss = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gd
    print_hex_gen #(.DATA_W(32), .PREFIX_EN(g == 2), .LOWER(g == 1)) u (
      .clk(clk), .rstn(rstn), .din(din), .mode(mode), .nl(nl),
      .req_tx(req[g]), .ack_tx(ack[g]), .d_tx(dtx[g]), .vld_tx(vld[g]),
      .rdy_tx(rdy[g]), .busy(busy[g])
    );
  end

  function automatic logic [7:0] hexc(input int u, input logic [3:0] x);
    if (x < 10) return 8'h30 + 8'(x);
    return ((u == 1) ? 8'h61 : 8'h41) + 8'(x) - 8'd10;
  endfunction

  // Expected byte stream for unit u (0 plain, 1 lowercase, 2 with "0x").
  function automatic void build(input int u, input logic [31:0] v, input logic [1:0] m, input logic n);
    bit started;
    exp_q.delete();
    if (u == 2 && (m == 2'd1 || m == 2'd2)) begin
      exp_q.push_back(8'h30);
      exp_q.push_back(8'h78);
    end
    if (m == 2'd0) exp_q.push_back(v[7:0]);
    else if (m == 2'd3) for (int i = 3; i >= 0; i--) exp_q.push_back(v[8*i +: 8]);
    else begin
      started = (m == 2'd1);
      for (int i = 7; i >= 0; i--) begin
        if (v[4*i +: 4] != 4'h0 || i == 0) started = 1'b1;
        if (started) exp_q.push_back(hexc(u, v[4*i +: 4]));
      end
    end
    if (n) begin
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
    end
  endfunction

  task automatic xfer(input int u, input logic [31:0] v, input logic [1:0] m, input logic n,
                      input int stall, input bit drop, input bit hold);
    int got, guard, st;
    logic [7:0] held;
    build(u, v, m, n);
    din = v; mode = m; nl = n; rdy[u] = (stall == 0); req[u] = 1'b1;
    @(negedge clk);
    din = $urandom; mode = 2'($urandom); nl = 1'($urandom);
    if (drop) req[u] = 1'b0;
    vec++;
    if (vld[u] !== 1'b1) begin miss++; $display("FAIL latency u%0d: vld_tx=%b required 1", u, vld[u]); end
    got = 0; guard = 0; st = 0; held = dtx[u];
    while (got < exp_q.size() && guard < 400) begin
      guard++;
      if (vld[u] !== 1'b1) begin
        vec++; miss++;
        $display("FAIL gap u%0d byte %0d: vld_tx=%b required 1", u, got, vld[u]);
        break;
      end
      if (st < stall) begin
        if (st == 0) held = dtx[u];
        else begin
          vec++;
          if (dtx[u] !== held) begin miss++; $display("FAIL stall u%0d byte %0d: d_tx=%h required %h", u, got, dtx[u], held); end
        end
        rdy[u] = 1'b0; st++;
      end else begin
        rdy[u] = 1'b1; vec++;
        if (dtx[u] !== exp_q[got]) begin miss++; $display("FAIL byte u%0d #%0d: d_tx=%h required %h", u, got, dtx[u], exp_q[got]); end
        got++; st = 0;
      end
      @(negedge clk);
    end
    rdy[u] = 1'b0;
    if (got < exp_q.size()) begin vec++; miss++; $display("FAIL count u%0d: %0d bytes required %0d", u, got, exp_q.size()); end
    vec++;
    if (vld[u] !== 1'b0 || ack[u] !== 1'b1) begin
      miss++; $display("FAIL end u%0d: vld_tx=%b ack_tx=%b required 0 1", u, vld[u], ack[u]);
    end
    if (hold) repeat (3) begin
      @(negedge clk); vec++;
      if (ack[u] !== 1'b1 || vld[u] !== 1'b0) begin
        miss++; $display("FAIL hold u%0d: ack_tx=%b vld_tx=%b required 1 0", u, ack[u], vld[u]);
      end
    end
    req[u] = 1'b0;
    @(negedge clk); vec++;
    if (ack[u] !== 1'b0 || busy[u] !== 1'b0) begin
      miss++; $display("FAIL release u%0d: ack_tx=%b busy=%b required 0 0", u, ack[u], busy[u]);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vec++;
      if ({ack[i], vld[i], busy[i], dtx[i]} !== 11'h0) begin
        miss++; $display("FAIL reset u%0d: ack/vld/busy/d_tx=%b%b%b %h required 000 00", i, ack[i], vld[i], busy[i], dtx[i]);
      end
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    xfer(0, 32'h1234ABCD, 2'd1, 1'b0, 0, 1'b0, 1'b0);
    xfer(0, 32'h000000F0, 2'd2, 1'b1, 0, 1'b0, 1'b0);
    xfer(0, 32'h00000000, 2'd2, 1'b0, 0, 1'b0, 1'b0);
    xfer(0, 32'hDEADBE5A, 2'd0, 1'b0, 0, 1'b0, 1'b0);
    xfer(0, 32'hDEADBE5A, 2'd3, 1'b0, 0, 1'b0, 1'b0);
    xfer(1, 32'hABCDEF01, 2'd1, 1'b0, 0, 1'b0, 1'b0);
    xfer(2, 32'h0000000A, 2'd1, 1'b0, 0, 1'b0, 1'b1);
    xfer(2, 32'h80000000, 2'd2, 1'b1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_stall;
    xfer(0, 32'h1234ABCD, 2'd1, 1'b0, 5, 1'b0, 1'b0);
    xfer(2, 32'h00C0FFEE, 2'd2, 1'b1, 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid;
    din = 32'h1234ABCD; mode = 2'd1; nl = 1'b0; rdy[0] = 1'b1; req[0] = 1'b1;
    repeat (4) @(negedge clk);
    #2 rstn = 1'b0;
    #1 vec++;
    if ({ack[0], vld[0], busy[0], dtx[0]} !== 11'h0) begin
      miss++; $display("FAIL midreset: ack/vld/busy/d_tx=%b%b%b %h required 000 00", ack[0], vld[0], busy[0], dtx[0]);
    end
    @(negedge clk);
    req[0] = 1'b0; rdy[0] = 1'b0; rstn = 1'b1;
    repeat (3) begin
      @(negedge clk); vec++;
      if (ack[0] !== 1'b0 || vld[0] !== 1'b0) begin
        miss++; $display("FAIL postreset: ack_tx=%b vld_tx=%b required 0 0", ack[0], vld[0]);
      end
    end
    xfer(0, 32'h1234ABCD, 2'd1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++)
      xfer($urandom_range(0, 2), $urandom >> ($urandom_range(0, 8) * 4), 2'($urandom), 1'($urandom),
           $urandom_range(0, 2), $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
